phase_profiler: RTL and testbench
=================================

Name: phase_profiler

Overview:
Parametrised multi-phase cycle profiler for benchmarking firmware running on the picoRV32 SoC, e.g. the MNIST inference stages. It times up to NUM_PHASES back-to-back software phases. Each phase ends when its watched memory word equals a marker value. It provides per-phase saturating counters, sticky overflow flags, done flags and a total-cycle counter. The counters are read by the host/testbench.

Parameters:
NUM_PHASES, 2, number of chained phases (1..16)
CNT_W, 32, width of each phase counter and of total_cycles
DATA_W, 32, width of each watched data word
MARKER, 32'h7fffffff, value of the watched word that ends a phase

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; clears all state and begins phase 0
rdata  input  NUM_PHASES*DATA_W  watched words; slice k (bits k*DATA_W +: DATA_W) ends phase k
counters  output  NUM_PHASES*CNT_W  per-phase cycle counts, slice k for phase k
overflow  output  NUM_PHASES  sticky; phase k counter saturated
phase_done  output  NUM_PHASES  sticky; phase k has seen its marker
cur_phase  output  $clog2(NUM_PHASES) (min 1)  index of the active phase; 0 when idle
busy  output  1  high while the FSM is in RUN
all_done  output  1  high while the FSM is in DONE
total_cycles  output  CNT_W  saturating count of all RUN cycles

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; counters, overflow, phase_done, cur_phase and total_cycles all 0; busy=0; all_done=0.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE -> RUN on start. At that edge all counters, flags and total_cycles clear and cur_phase=0.
- RUN, active phase k, each clock edge:
  - If rdata slice k == MARKER: set phase_done[k]; counter k holds (the marker cycle is not counted). If k < NUM_PHASES-1, cur_phase=k+1; otherwise go to DONE.
  - Otherwise counter k increments by 1.
  - total_cycles increments on every RUN cycle, including marker cycles.
- A marker on slice j != cur_phase is ignored. Inactive counters hold.
- Saturation: a counter at 2^CNT_W-1 holds and its overflow bit is set. This also applies to total_cycles, whose overflow is not flagged. Overflow does not stop phase progression.
- Markers on slices k and k+1 in the same cycle: only phase k ends. Phase k+1 is evaluated from the next cycle. If its marker is still present, it ends with count 0.
- DONE: all values hold; all_done=1 until the next start.
- start in RUN or DONE: immediate restart (same clear as from IDLE). start takes priority over a marker in the same cycle.
- Reset mid-run: asynchronous clear to the reset values, return to IDLE.
- Latency: start at edge t. If phase 0's marker is first seen at edge t+1+n, then counter0 = n and phase_done[0] rises at that edge.

Decomposition:
- Shared package profiler_pkg:
  - state typedef (IDLE/RUN/DONE)
  - default MARKER constant
  - a helper function for counter slice indexing
- One natural sub-module: sat_counter. It is a CNT_W saturating counter with clr, inc, value and sat outputs. It is instantiated NUM_PHASES+1 times (the phases plus total).
- The FSM and marker compare stay in the top level.

Test Plan:
- Reset then idle: resetn low 3 cycles, then high with no start for 10 cycles -> all outputs 0, busy=0.
- Basic chain (NUM_PHASES=2): start; slice0=MARKER after 100 cycles; slice1=MARKER 50 cycles later -> counters={50,100}, phase_done=2'b11, all_done=1, total_cycles=152.
- Early/ignored marker: slice1=MARKER held from start, slice0 marker at 20 -> counter0=20, counter1=0, phase_done[1] set at the cycle after phase 0 ends.
- Saturation (CNT_W=4): phase 0 runs 30 cycles -> counter0=15, overflow[0]=1; a marker still advances to phase 1.
- Restart: start pulse in the same cycle as the slice0 marker, mid-RUN -> counters cleared, phase_done=0, cur_phase=0, busy=1.
- Async reset mid-run: resetn low between clock edges in RUN -> outputs clear immediately with no clock edge, state IDLE.

Source files
------------

// File: rtl/profiler_pkg.sv
// rtl/profiler_pkg.sv - shared types, constants and slice helper for the phase profiler
package profiler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_MARKER = 32'h7fffffff;

   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] value,
   output logic         sat
);

   assign sat = &value;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc && !sat) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/phase_profiler.sv
// rtl/phase_profiler.sv - chained per-phase cycle profiler with marker-terminated phases
module phase_profiler
   import profiler_pkg::*;
#(
   parameter int                NUM_PHASES = 2,
   parameter int                CNT_W      = 32,
   parameter int                DATA_W     = 32,
   parameter logic [DATA_W-1:0] MARKER     = DATA_W'(DEFAULT_MARKER),
   localparam int               CP_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic [NUM_PHASES*DATA_W-1:0] rdata,
   output logic [NUM_PHASES*CNT_W-1:0]  counters,
   output logic [NUM_PHASES-1:0]      overflow,
   output logic [NUM_PHASES-1:0]      phase_done,
   output logic [CP_W-1:0]            cur_phase,
   output logic                       busy,
   output logic                       all_done,
   output logic [CNT_W-1:0]           total_cycles
);

   state_t                state_q, state_d;
   logic                  clr, run;
   logic [NUM_PHASES-1:0] hit, inc, sat;
   logic                  active_hit, last_phase;
   logic                  total_sat;

   assign active_hit = hit[cur_phase];
   assign last_phase = (cur_phase == CP_W'(NUM_PHASES - 1));
   assign busy       = (state_q == ST_RUN);
   assign all_done   = (state_q == ST_DONE);

   // Only the active phase's slice is compared for counting; others are ignored.
   for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
      assign hit[k] = (rdata[slice_lo(k, DATA_W) +: DATA_W] == MARKER);
      assign inc[k] = run && !hit[k] && (cur_phase == CP_W'(k));

      sat_counter #(.W(CNT_W)) u_cnt (
         .clk    (clk),
         .resetn (resetn),
         .clr    (clr),
         .inc    (inc[k]),
         .value  (counters[slice_lo(k, CNT_W) +: CNT_W]),
         .sat    (sat[k])
      );
   end

   sat_counter #(.W(CNT_W)) u_total (
      .clk    (clk),
      .resetn (resetn),
      .clr    (clr),
      .inc    (run),
      .value  (total_cycles),
      .sat    (total_sat)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // start wins over any marker seen in the same cycle.
   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      run     = 1'b0;
      if (start) begin
         clr     = 1'b1;
         state_d = ST_RUN;
      end else if (state_q == ST_RUN) begin
         run = 1'b1;
         if (active_hit && last_phase) begin
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cur_phase  <= '0;
         phase_done <= '0;
         overflow   <= '0;
      end else if (clr) begin
         cur_phase  <= '0;
         phase_done <= '0;
         overflow   <= '0;
      end else if (run) begin
         overflow <= overflow | (inc & sat);
         if (active_hit) begin
            phase_done[cur_phase] <= 1'b1;
            if (!last_phase) begin
               cur_phase <= cur_phase + CP_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_phase_profiler.sv
// tb/tb_phase_profiler.sv - directed scoreboard bench for phase_profiler
module tb_phase_profiler;

   localparam logic [31:0] MK = 32'h7fffffff;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start, start_s;
   logic [63:0] rdata, rdata_s;

   logic [63:0] counters;
   logic [1:0]  overflow, phase_done;
   logic        cur_phase, busy, all_done;
   logic [31:0] total_cycles;

   logic [7:0]  counters_s;
   logic [1:0]  overflow_s, phase_done_s;
   logic        cur_phase_s, busy_s, all_done_s;
   logic [3:0]  total_s;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       tag;
      logic [63:0] exp;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   phase_profiler u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .rdata        (rdata),
      .counters     (counters),
      .overflow     (overflow),
      .phase_done   (phase_done),
      .cur_phase    (cur_phase),
      .busy         (busy),
      .all_done     (all_done),
      .total_cycles (total_cycles)
   );

   phase_profiler #(.NUM_PHASES(2), .CNT_W(4)) u_sat (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start_s),
      .rdata        (rdata_s),
      .counters     (counters_s),
      .overflow     (overflow_s),
      .phase_done   (phase_done_s),
      .cur_phase    (cur_phase_s),
      .busy         (busy_s),
      .all_done     (all_done_s),
      .total_cycles (total_s)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input string tag, input logic [63:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sbq.push_back(x);
   endtask

   task automatic pop_chk(input logic [63:0] obs);
      exp_t x;
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 64'd0, 64'd1);
      end else begin
         x = sbq.pop_front();
         chk(x.tag, obs, x.exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_all_done(input int budget);
      for (int i = 0; i < budget && !all_done; i++) tick(1);
      chk("all_done_wait", 64'(all_done), 64'd1);
   endtask

   initial begin
      resetn  = 1'b0;
      start   = 1'b0;
      start_s = 1'b0;
      rdata   = '0;
      rdata_s = '0;

      // reset then idle
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      tick(10);
      push("rst_counters", 64'd0);   pop_chk(counters);
      push("rst_overflow", 64'd0);   pop_chk(64'(overflow));
      push("rst_done", 64'd0);       pop_chk(64'(phase_done));
      push("rst_cur_phase", 64'd0);  pop_chk(64'(cur_phase));
      push("rst_busy", 64'd0);       pop_chk(64'(busy));
      push("rst_all_done", 64'd0);   pop_chk(64'(all_done));
      push("rst_total", 64'd0);      pop_chk(64'(total_cycles));

      // basic chain: 100 cycles then 50 cycles
      start = 1'b1; tick(1); start = 1'b0;
      push("run_busy", 64'd1);       pop_chk(64'(busy));
      tick(100);
      rdata[31:0] = MK;
      push("p0_count", 64'd100);
      push("p0_done", 64'd1);
      push("p0_cur_phase", 64'd1);
      tick(1);
      rdata[31:0] = '0;
      pop_chk(64'(counters[31:0]));
      pop_chk(64'(phase_done));
      pop_chk(64'(cur_phase));
      tick(50);
      rdata[63:32] = MK;
      push("chain_counters", {32'd50, 32'd100});
      push("chain_done", 64'd3);
      push("chain_total", 64'd152);
      push("chain_busy", 64'd0);
      tick(1);
      rdata[63:32] = '0;
      wait_all_done(5);
      pop_chk(counters);
      pop_chk(64'(phase_done));
      pop_chk(64'(total_cycles));
      pop_chk(64'(busy));
      tick(5);
      push("done_hold", {32'd50, 32'd100});
      pop_chk(counters);

      // slice1 marker held from start: ignored until phase 1 is active
      rdata[63:32] = MK;
      start = 1'b1; tick(1); start = 1'b0;
      tick(20);
      push("early_c1_ignored", 64'd0); pop_chk(64'(counters[63:32]));
      push("early_no_done", 64'd0);    pop_chk(64'(phase_done));
      rdata[31:0] = MK;
      tick(1);
      rdata[31:0] = '0;
      push("early_c0", 64'd20);        pop_chk(64'(counters[31:0]));
      push("early_done0", 64'd1);      pop_chk(64'(phase_done));
      tick(1);
      push("early_done1", 64'd3);      pop_chk(64'(phase_done));
      push("early_c1", 64'd0);         pop_chk(64'(counters[63:32]));
      push("early_all_done", 64'd1);   pop_chk(64'(all_done));
      push("early_total", 64'd22);     pop_chk(64'(total_cycles));
      rdata = '0;

      // saturation with 4-bit counters
      start_s = 1'b1; tick(1); start_s = 1'b0;
      tick(30);
      push("sat_c0", 64'd15);          pop_chk(64'(counters_s[3:0]));
      push("sat_ovf", 64'd1);          pop_chk(64'(overflow_s));
      rdata_s[31:0] = MK;
      tick(1);
      rdata_s[31:0] = '0;
      push("sat_cur_phase", 64'd1);    pop_chk(64'(cur_phase_s));
      push("sat_done0", 64'd1);        pop_chk(64'(phase_done_s));
      push("sat_total", 64'd15);       pop_chk(64'(total_s));

      // restart coinciding with a slice0 marker
      start = 1'b1; tick(1); start = 1'b0;
      tick(10);
      push("pre_restart_c0", 64'd10);  pop_chk(64'(counters[31:0]));
      rdata[31:0] = MK;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      rdata = '0;
      push("rs_counters", 64'd0);      pop_chk(counters);
      push("rs_done", 64'd0);          pop_chk(64'(phase_done));
      push("rs_cur_phase", 64'd0);     pop_chk(64'(cur_phase));
      push("rs_busy", 64'd1);          pop_chk(64'(busy));
      push("rs_total", 64'd0);         pop_chk(64'(total_cycles));

      // asynchronous reset between edges
      tick(5);
      push("ar_pre_c0", 64'd5);        pop_chk(64'(counters[31:0]));
      #2 resetn = 1'b0;
      #1;
      push("ar_counters", 64'd0);      pop_chk(counters);
      push("ar_total", 64'd0);         pop_chk(64'(total_cycles));
      push("ar_busy", 64'd0);          pop_chk(64'(busy));
      push("ar_sat_done", 64'd0);      pop_chk(64'(phase_done_s));
      #1 resetn = 1'b1;
      tick(3);
      push("ar_idle_busy", 64'd0);     pop_chk(64'(busy));
      push("ar_idle_total", 64'd0);    pop_chk(64'(total_cycles));

      if (sbq.size() != 0) chk("scoreboard_leftover", 64'(sbq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
